multicycle_control: RTL

Parametrised multi-cycle control unit for the datapath, superseding the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states and drives every datapath strobe. It stalls on a ready/valid memory handshake and traps on bus timeout or illegal opcode. It sits between the instruction register opcode field and the datapath mux and enable inputs.

---
 rtl/ctrl_pkg.sv | 45 ++++
 rtl/ctrl_wait_timer.sv | 40 ++++
 rtl/multicycle_control.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states and the
// datapath mux select codes. CTRL_JUMP_EN enables the JMP opcode (5); without it
// opcode 5 decodes as illegal.
package ctrl_pkg;

  localparam int unsigned OP_RTYPE = 0;
  localparam int unsigned OP_LW    = 1;
  localparam int unsigned OP_SW    = 2;
  localparam int unsigned OP_BEQ   = 3;
  localparam int unsigned OP_ADDI  = 4;
  localparam int unsigned OP_JMP   = 5;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMemAcc,
    StWb,
    StHalt
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // True for opcodes this build can execute.
  function automatic logic op_legal(input int unsigned op);
`ifdef CTRL_JUMP_EN
    return op <= OP_JMP;
`else
    return op <= OP_ADDI;
`endif
  endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Counts ready-low cycles of one memory access. expire_o fires on a tick that
// arrives with the count already at WAIT_MAX; WAIT_MAX = 0 never expires.
module ctrl_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic tick_i,
  output logic expire_o
);

  localparam int unsigned CntW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  logic [CntW-1:0] count_q, count_d;
  logic            at_max;

  assign at_max   = (count_q == CntW'(WAIT_MAX));
  assign expire_o = (WAIT_MAX != 0) && tick_i && at_max;

  // Clear has priority; saturate at WAIT_MAX since the FSM leaves on expiry.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (tick_i && !at_max) begin
      count_d = count_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEMACC/WB sequencing with a
// ready-stalled memory handshake, bus-timeout trap to HALT and illegal-opcode skip.
// Optional feature macro: CTRL_JUMP_EN (enables opcode 5 = JMP).
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned OP_W     = 4,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [OP_W-1:0] opcode_i,
  input  logic            mem_ready_i,
  output logic            pc_write_o,
  output logic            pc_write_cond_o,
  output logic            ir_write_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            iord_o,
  output logic            mem_to_reg_o,
  output logic            reg_dst_o,
  output logic            reg_write_o,
  output logic            alu_src_a_o,
  output logic [1:0]      alu_src_b_o,
  output logic [1:0]      alu_op_o,
  output logic [1:0]      pc_src_o,
  output logic            illegal_o,
  output logic            bus_err_o
);

  state_e          state_q;
  logic [OP_W-1:0] op_q;
  int unsigned     op_now, op_held;
  logic            legal;
  logic            wait_st, tmr_tick, tmr_expire;

  assign op_now  = 32'(opcode_i);
  assign op_held = 32'(op_q);
  assign legal   = op_legal(op_now);

  // The timer only runs while stalled; any other cycle (including the ready
  // cycle that leaves FETCH/MEMACC) clears it, so each access starts from zero.
  assign wait_st  = (state_q == StFetch) || (state_q == StMemAcc);
  assign tmr_tick = wait_st && !mem_ready_i;

  ctrl_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (!tmr_tick),
    .tick_i  (tmr_tick),
    .expire_o(tmr_expire)
  );

  // State sequencing; the opcode is captured in EXEC for MEMACC and WB.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      op_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: state_q <= StFetch;
        StFetch: begin
          if (mem_ready_i) begin
            state_q <= StDecode;
          end else if (tmr_expire) begin
            state_q <= StHalt;
          end
        end
        StDecode: state_q <= legal ? StExec : StFetch;
        StExec: begin
          op_q <= opcode_i;
          if (op_now == OP_RTYPE || op_now == OP_ADDI) begin
            state_q <= StWb;
          end else if (op_now == OP_LW || op_now == OP_SW) begin
            state_q <= StMemAcc;
          end else begin
            state_q <= StFetch;
          end
        end
        StMemAcc: begin
          if (mem_ready_i) begin
            state_q <= (op_held == OP_LW) ? StWb : StFetch;
          end else if (tmr_expire) begin
            state_q <= StHalt;
          end
        end
        StWb:    state_q <= StFetch;
        StHalt:  state_q <= StHalt;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Moore decode of the datapath strobes; only FETCH's IR/PC enables see mem_ready.
  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    ir_write_o      = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    iord_o          = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_dst_o       = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = SRCB_RT;
    alu_op_o        = ALU_ADD;
    pc_src_o        = PC_ALU;
    illegal_o       = 1'b0;
    bus_err_o       = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_ONE;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      StDecode: begin
        alu_src_b_o = SRCB_BOFF;
        illegal_o   = !legal;
      end
      StExec: begin
        case (op_now)
          OP_RTYPE: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = ALU_FUNCT;
          end
          OP_LW, OP_SW, OP_ADDI: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SRCB_IMM;
          end
          OP_BEQ: begin
            alu_src_a_o     = 1'b1;
            alu_op_o        = ALU_SUB;
            pc_write_cond_o = 1'b1;
            pc_src_o        = PC_ALUOUT;
          end
`ifdef CTRL_JUMP_EN
          OP_JMP: begin
            pc_write_o = 1'b1;
            pc_src_o   = PC_JUMP;
          end
`endif
          default: ;
        endcase
      end
      StMemAcc: begin
        iord_o      = 1'b1;
        mem_read_o  = (op_held == OP_LW);
        mem_write_o = (op_held == OP_SW);
      end
      StWb: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = (op_held == OP_RTYPE);
        mem_to_reg_o = (op_held == OP_LW);
      end
      StHalt:  bus_err_o = 1'b1;
      default: ;
    endcase
  end

endmodule
